dmem_lsu: RTL
=============

# dmem_lsu

Load/store unit that is the initiator side of the data-memory port. Accepts one RV32I load or store per handshake from the execute stage and drives the word-wide data memory's read port (combinational read data) and write port (written on clk edge). Performs address translation to word index, misalignment checking, load lane extraction with sign/zero extension, and read-modify-write for byte and halfword stores, because the memory only writes whole words.

## Interface
- No parameters.
- clk  in  1  core clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  LSU can accept a request (high only in IDLE)
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I width: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  one-cycle completion pulse; core always accepts
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned or illegal funct3; valid with rsp_valid
- mem_r_addr  out  32  word index {2'b00, addr[31:2]}
- mem_w_addr  out  32  word index {2'b00, addr[31:2]}
- mem_data_in  out  32  write word
- mem_read  out  1  read strobe
- mem_write  out  1  write strobe; never high with mem_read
- mem_data_out  in  32  read word, combinational from mem_r_addr

## Operation
- States: IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP.
- IDLE: req_ready=1. On req_valid, latch addr/wdata/funct3/we; next state:
  - illegal funct3 (load 011/110/111, store ≥011) or misaligned (see Configuration) -> RESP, rsp_err=1, no memory access
  - load -> LOAD; store W -> STORE; store B/H -> RMW_RD
- LOAD: mem_read=1; at edge capture lane from mem_data_out: B/BU lane addr[1:0], H/HU lane addr[1]; B/H sign-extend, BU/HU zero-extend, W unmodified -> RESP.
- STORE: mem_write=1, mem_data_in=wdata -> RESP.
- RMW_RD: mem_read=1; capture mem_data_out into merge register -> RMW_WR.
- RMW_WR: mem_write=1, mem_data_in = captured word with byte lane addr[1:0] replaced by wdata[7:0] (B) or half lane addr[1] replaced by wdata[15:0] (H) -> RESP.
- RESP: rsp_valid=1 for exactly one cycle -> IDLE.
- mem_* strobes are Moore outputs of the state register; addresses held stable from the state after IDLE through RESP; idle values: addresses 0, mem_data_in 0.
- One request in flight; no back-to-back acceptance.

## Timing
- Handshake in cycle 0 (req_valid & req_ready).
- Load / word store: memory cycle 1, rsp_valid cycle 2.
- Sub-word store: read cycle 1, write cycle 2, rsp_valid cycle 3.
- Error: rsp_valid cycle 1.
- Next request accepted earliest the cycle after rsp_valid.
- Reset (all outputs): req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_read=0, mem_write=0, addresses/data 0, state IDLE.
- Reset mid-operation: strobes drop asynchronously; pending request discarded, no response, no partial write (RMW_RD reset means no write occurs).

## Configuration
- LSU_MISALIGN_TRAP_EN defined: H at odd address or W with addr[1:0]≠0 -> error response, no access.
- Undefined: no misalignment error; low address bits ignored for alignment (H uses addr[1], W uses word addr[31:2]); rsp_err only for illegal funct3.

## Test plan
- SW addr 0x10 data 0xDEADBEEF then LW 0x10 -> mem_write with mem_w_addr=4 in cycle 1; load rsp_rdata=0xDEADBEEF, rsp_valid cycle 2.
- Word 0x11223344 at 0x20; SB 0x21 data 0xAA -> cycle 1 read, cycle 2 write 0x1122AA44, rsp_valid cycle 3.
- Word 0x80FF7F01 at 0x30; LB 0x32 -> 0xFFFFFFFF; LBU 0x32 -> 0x000000FF; LH 0x32 -> 0xFFFF80FF; LHU 0x30 -> 0x00007F01.
- LW 0x13 with macro -> rsp_err=1 cycle 1, mem_read never high; without macro -> reads word index 4, rsp_err=0.
- funct3=011 load -> rsp_err=1, rsp_rdata=0, no strobes.
- rst_n low during RMW_RD of SH -> mem_read drops immediately, no mem_write, no rsp_valid, req_ready=1 after release.

Source files
------------

// File: rtl/dmem_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_lsu
//  Purpose  : RV32I load/store unit driving a word-wide data memory.
//             Accepts one load or store per handshake, translates the byte
//             address to a word index, checks funct3 legality (and optionally
//             alignment), extracts and extends load lanes, and performs
//             read-modify-write for byte/halfword stores because the memory
//             only accepts whole-word writes.
//  Optional : define LSU_MISALIGN_TRAP_EN to return an error for halfword
//             accesses at odd addresses and word accesses with addr[1:0]!=0.
//             Without it the low address bits are ignored for alignment.
//  Ports    :
//    clk, rst_n        core clock, asynchronous active-low reset
//    req_valid/ready   request handshake (ready only while idle)
//    req_we            1 = store, 0 = load
//    req_funct3        RV32I width code (B/H/W/BU/HU)
//    req_addr          byte address
//    req_wdata         right-aligned store data
//    rsp_valid         one-cycle completion pulse
//    rsp_rdata         extended load data, 0 for stores and errors
//    rsp_err           illegal funct3 or misaligned access
//    mem_r_addr        read word index
//    mem_w_addr        write word index
//    mem_data_in       word written to memory
//    mem_read          read strobe
//    mem_write         write strobe
//    mem_data_out      combinational read word
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_lsu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_r_addr,
  output logic [31:0] mem_w_addr,
  output logic [31:0] mem_data_in,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_data_out
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_STORE  = 3'd2,
    S_RMW_RD = 3'd3,
    S_RMW_WR = 3'd4,
    S_RESP   = 3'd5
  } state_t;

  state_t      state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  funct3_q;
  logic [31:0] merge_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        f3_illegal;
  logic        misalign;
  logic        req_bad;
  logic [31:0] load_ext;
  logic [31:0] merged;
  logic [31:0] word_idx;

  // Loads accept B/H/W/BU/HU; stores only B/H/W.
  always_comb begin
    f3_illegal = 1'b0;
    if (req_we)
      f3_illegal = (req_funct3 > 3'b010);
    else
      f3_illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                   (req_funct3 == 3'b111);
  end

`ifdef LSU_MISALIGN_TRAP_EN
  // funct3[1:0] is 01 for H/HU and 10 for W in every legal encoding.
  always_comb begin
    misalign = 1'b0;
    if (req_funct3[1:0] == 2'b01)
      misalign = req_addr[0];
    else if (req_funct3[1:0] == 2'b10)
      misalign = (req_addr[1:0] != 2'b00);
  end
`else
  assign misalign = 1'b0;
`endif

  assign req_bad = f3_illegal | misalign;

  // Lane extraction from the combinational read word.
  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    case (addr_q[1:0])
      2'd0:    b = mem_data_out[7:0];
      2'd1:    b = mem_data_out[15:8];
      2'd2:    b = mem_data_out[23:16];
      default: b = mem_data_out[31:24];
    endcase
    h = addr_q[1] ? mem_data_out[31:16] : mem_data_out[15:0];
    case (funct3_q)
      3'b000:  load_ext = {{24{b[7]}}, b};
      3'b100:  load_ext = {24'd0, b};
      3'b001:  load_ext = {{16{h[15]}}, h};
      3'b101:  load_ext = {16'd0, h};
      default: load_ext = mem_data_out;
    endcase
  end

  // Merge store data into the word captured during RMW_RD.
  always_comb begin
    merged = merge_q;
    if (funct3_q[0] == 1'b0) begin
      case (addr_q[1:0])
        2'd0:    merged[7:0]   = wdata_q[7:0];
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merged[31:16] = wdata_q[15:0];
    end else begin
      merged[15:0]  = wdata_q[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      funct3_q <= 3'd0;
      merge_q  <= 32'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            funct3_q <= req_funct3;
            rdata_q  <= 32'd0;
            err_q    <= req_bad;
            if (req_bad)
              state <= S_RESP;
            else if (!req_we)
              state <= S_LOAD;
            else if (req_funct3 == 3'b010)
              state <= S_STORE;
            else
              state <= S_RMW_RD;
          end
        end
        S_LOAD: begin
          rdata_q <= load_ext;
          state   <= S_RESP;
        end
        S_STORE:  state <= S_RESP;
        S_RMW_RD: begin
          merge_q <= mem_data_out;
          state   <= S_RMW_WR;
        end
        S_RMW_WR: state <= S_RESP;
        S_RESP:   state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  // All outputs decode directly from registered state, so an asynchronous
  // reset removes the strobes immediately.
  assign word_idx    = {2'b00, addr_q[31:2]};
  assign req_ready   = (state == S_IDLE);
  assign mem_read    = (state == S_LOAD) || (state == S_RMW_RD);
  assign mem_write   = (state == S_STORE) || (state == S_RMW_WR);
  assign mem_r_addr  = (state == S_IDLE) ? 32'd0 : word_idx;
  assign mem_w_addr  = (state == S_IDLE) ? 32'd0 : word_idx;
  assign mem_data_in = (state == S_STORE)  ? wdata_q :
                       (state == S_RMW_WR) ? merged  : 32'd0;
  assign rsp_valid   = (state == S_RESP);
  assign rsp_rdata   = (state == S_RESP) ? rdata_q : 32'd0;
  assign rsp_err     = (state == S_RESP) && err_q;

endmodule
`default_nettype wire
